// File: rtl/pic_control_unit.sv
// -----------------------------------------------------------------------------
// pic_control_unit
//
// Clocked bus/control front end of an 8259-style PIC. Decodes CPU writes into
// the ICW1..ICW4 initialisation sequence and OCW1..OCW3, sequences the
// two-pulse INTA handshake, issues one-cycle commands to the priority block
// and returns status bytes / the interrupt vector on DOUT.
//
// Optional feature macro: PIC_ICW3_EN
//   defined   -> ICW3 state and cascade latch present (SNGL=0 needs ICW3)
//   undefined -> no ICW3 state, SNGL ignored
//
// Ports:
//   CLK, RST_N            clock (rising edge), asynchronous active-low reset
//   CS_N, WR_N, RD_N, A0  CPU bus strobes / register select
//   DIN[7:0]              CPU write data
//   INTA_N                interrupt acknowledge strobe
//   PRIORITY_DATA[7:0]    response data from the priority block
//   PRIORITY_MODE[2:0]    response tag (3'b101 = vector level valid)
//   CU_MODE/CU_DATA       command + payload to the priority block
//   CU_WRITE              one-cycle command strobe
//   DOUT/DOUT_EN          read / vector data to the CPU and its drive enable
//   READY                 initialisation complete
// -----------------------------------------------------------------------------
module pic_control_unit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       CS_N,
    input  logic       WR_N,
    input  logic       RD_N,
    input  logic       A0,
    input  logic [7:0] DIN,
    input  logic       INTA_N,
    input  logic [7:0] PRIORITY_DATA,
    input  logic [2:0] PRIORITY_MODE,
    output logic [2:0] CU_MODE,
    output logic [7:0] CU_DATA,
    output logic       CU_WRITE,
    output logic [7:0] DOUT,
    output logic       DOUT_EN,
    output logic       READY
);

    typedef enum logic [2:0] {
        ST_UNINIT = 3'd0,
        ST_ICW2   = 3'd1,
`ifdef PIC_ICW3_EN
        ST_ICW3   = 3'd2,
`endif
        ST_ICW4   = 3'd3,
        ST_OPER   = 3'd4
    } state_t;

    localparam logic [2:0] CMD_RD_IRR = 3'b000;
    localparam logic [2:0] CMD_RD_ISR = 3'b001;
    localparam logic [2:0] CMD_WR_IMR = 3'b010;
    localparam logic [2:0] CMD_OCW2   = 3'b011;
    localparam logic [2:0] CMD_INIT   = 3'b100;
    localparam logic [2:0] CMD_IDLE   = 3'b101;
    localparam logic [2:0] CMD_INTA   = 3'b110;
    localparam logic [2:0] CMD_RESET  = 3'b111;

    // Strobe synchronisers (idle high) and previous synchronised values.
    logic [SYNC_STAGES-1:0] wr_sync_q, wr_sync_d;
    logic [SYNC_STAGES-1:0] rd_sync_q, rd_sync_d;
    logic [SYNC_STAGES-1:0] inta_sync_q, inta_sync_d;
    logic wr_prev_q, wr_prev_d, rd_prev_q, rd_prev_d, inta_prev_q, inta_prev_d;

    // Bus sample taken while synchronised WR_N is low.
    logic       a0_lat_q, a0_lat_d, cs_lat_q, cs_lat_d;
    logic [7:0] din_lat_q, din_lat_d;

    // One-deep pending flags with their captured payloads.
    logic       ack_pend_q, ack_pend_d, wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d;
    logic       wr_a0_p_q, wr_a0_p_d, rd_a0_p_q, rd_a0_p_d;
    logic [7:0] wr_din_p_q, wr_din_p_d;

    // Initialisation / operating state.
    state_t     state_q, state_d;
    logic       ic4_q, ic4_d, ltim_q, ltim_d, aeoi_q, aeoi_d;
    logic       rsel_q, rsel_d, inta_cnt_q, inta_cnt_d;
    logic [4:0] base_q, base_d;
    logic [7:0] imr_q, imr_d;
`ifdef PIC_ICW3_EN
    logic       sngl_q, sngl_d;
    logic [7:0] cascade_q, cascade_d;
`endif

    // Deferred captures and DOUT_EN sources.
    logic prd_cap_q, prd_cap_d, vec_cap_q, vec_cap_d;
    logic rd_act_q, rd_act_d, inta_act_q, inta_act_d;

    // Registered outputs.
    logic [2:0] cu_mode_q, cu_mode_d;
    logic [7:0] cu_data_q, cu_data_d, dout_q, dout_d;
    logic       cu_write_q, cu_write_d, dout_en_q, dout_en_d, ready_q, ready_d;

    logic wr_s, rd_s, inta_s;
    logic wr_evt, rd_evt, ack_evt;
    logic ack_want, wr_want, rd_want;
    logic       w_a0, r_a0;
    logic [7:0] w_din;
    logic       finish;

    assign wr_s   = wr_sync_q[SYNC_STAGES-1];
    assign rd_s   = rd_sync_q[SYNC_STAGES-1];
    assign inta_s = inta_sync_q[SYNC_STAGES-1];

    assign wr_evt  = ~wr_prev_q & wr_s & ~cs_lat_q;
    assign rd_evt  = rd_prev_q & ~rd_s & ~CS_N;
    assign ack_evt = inta_prev_q & ~inta_s;

    // A fresh event is served straight away when its slot is free, so the
    // pending flag only costs latency when a higher-priority event wins.
    assign ack_want = ack_pend_q | ack_evt;
    assign wr_want  = wr_pend_q | wr_evt;
    assign rd_want  = rd_pend_q | rd_evt;

    assign w_a0  = wr_pend_q ? wr_a0_p_q  : a0_lat_q;
    assign w_din = wr_pend_q ? wr_din_p_q : din_lat_q;
    assign r_a0  = rd_pend_q ? rd_a0_p_q  : A0;

    always_comb begin
        wr_sync_d   = {wr_sync_q[SYNC_STAGES-2:0], WR_N};
        rd_sync_d   = {rd_sync_q[SYNC_STAGES-2:0], RD_N};
        inta_sync_d = {inta_sync_q[SYNC_STAGES-2:0], INTA_N};
        wr_prev_d   = wr_s;
        rd_prev_d   = rd_s;
        inta_prev_d = inta_s;

        a0_lat_d  = a0_lat_q;
        din_lat_d = din_lat_q;
        cs_lat_d  = cs_lat_q;
        if (!wr_s) begin
            a0_lat_d  = A0;
            din_lat_d = DIN;
            cs_lat_d  = CS_N;
        end

        ack_pend_d = ack_pend_q;
        wr_pend_d  = wr_pend_q;
        rd_pend_d  = rd_pend_q;
        wr_a0_p_d  = wr_pend_q ? wr_a0_p_q  : a0_lat_q;
        wr_din_p_d = wr_pend_q ? wr_din_p_q : din_lat_q;
        rd_a0_p_d  = rd_pend_q ? rd_a0_p_q  : A0;

        state_d    = state_q;
        ic4_d      = ic4_q;
        ltim_d     = ltim_q;
        aeoi_d     = aeoi_q;
        rsel_d     = rsel_q;
        inta_cnt_d = inta_cnt_q;
        base_d     = base_q;
        imr_d      = imr_q;
`ifdef PIC_ICW3_EN
        sngl_d     = sngl_q;
        cascade_d  = cascade_q;
`endif
        prd_cap_d  = 1'b0;
        vec_cap_d  = 1'b0;
        rd_act_d   = rd_act_q;
        inta_act_d = inta_act_q;
        cu_mode_d  = cu_mode_q;
        cu_data_d  = cu_data_q;
        cu_write_d = 1'b0;
        dout_d     = dout_q;
        finish     = 1'b0;

        // Captures requested by a command issued in the previous cycle.
        if (prd_cap_q) begin
            dout_d = PRIORITY_DATA;
        end
        if (vec_cap_q) begin
            dout_d     = {base_q, (PRIORITY_MODE == 3'b101) ? PRIORITY_DATA[2:0] : 3'b111};
            inta_act_d = 1'b1;
        end

        if (rd_evt) begin
            rd_act_d = 1'b1;
        end
        if (rd_s) begin
            rd_act_d = 1'b0;
        end
        if (inta_s) begin
            inta_act_d = 1'b0;
        end

        // One event served per cycle: ack > write > read.
        if (ack_want) begin
            ack_pend_d = 1'b0;
            wr_pend_d  = wr_want;
            rd_pend_d  = rd_want;
            if (state_q != ST_UNINIT) begin
                inta_cnt_d = ~inta_cnt_q;
                cu_write_d = 1'b1;
                cu_mode_d  = CMD_INTA;
                cu_data_d  = 8'h00;
                // Second pulse: the level arrives on PRIORITY_* next cycle.
                vec_cap_d  = inta_cnt_q;
            end
        end else if (wr_want) begin
            wr_pend_d = 1'b0;
            rd_pend_d = rd_want;
            if (!w_a0 && w_din[4]) begin
                ic4_d      = w_din[0];
                ltim_d     = w_din[3];
`ifdef PIC_ICW3_EN
                sngl_d     = w_din[1];
`endif
                aeoi_d     = 1'b0;
                rsel_d     = 1'b0;
                inta_cnt_d = 1'b0;
                cu_write_d = 1'b1;
                cu_mode_d  = CMD_RESET;
                cu_data_d  = w_din;
                state_d    = ST_ICW2;
            end else begin
                case (state_q)
                    ST_ICW2: begin
                        if (w_a0) begin
                            base_d = w_din[7:3];
`ifdef PIC_ICW3_EN
                            if (!sngl_q)    state_d = ST_ICW3;
                            else if (ic4_q) state_d = ST_ICW4;
                            else            finish  = 1'b1;
`else
                            if (ic4_q) state_d = ST_ICW4;
                            else       finish  = 1'b1;
`endif
                        end
                    end
`ifdef PIC_ICW3_EN
                    ST_ICW3: begin
                        if (w_a0) begin
                            cascade_d = w_din;
                            if (ic4_q) state_d = ST_ICW4;
                            else       finish  = 1'b1;
                        end
                    end
`endif
                    ST_ICW4: begin
                        if (w_a0) begin
                            aeoi_d = w_din[1];
                            finish = 1'b1;
                        end
                    end
                    ST_OPER: begin
                        if (w_a0) begin
                            imr_d      = w_din;
                            cu_write_d = 1'b1;
                            cu_mode_d  = CMD_WR_IMR;
                            cu_data_d  = w_din;
                        end else if (!w_din[3]) begin
                            cu_write_d = 1'b1;
                            cu_mode_d  = CMD_OCW2;
                            cu_data_d  = w_din;
                        end else if (w_din[1]) begin
                            rsel_d = w_din[0];
                        end
                    end
                    default: ;
                endcase
            end
            if (finish) begin
                cu_write_d = 1'b1;
                cu_mode_d  = CMD_INIT;
                cu_data_d  = {6'b0, ltim_q, aeoi_d};
                state_d    = ST_OPER;
            end
        end else if (rd_want) begin
            rd_pend_d = 1'b0;
            if (state_q == ST_UNINIT) begin
                dout_d = 8'h00;
            end else if (r_a0) begin
                dout_d = imr_q;
            end else begin
                cu_write_d = 1'b1;
                cu_mode_d  = rsel_q ? CMD_RD_ISR : CMD_RD_IRR;
                cu_data_d  = 8'h00;
                prd_cap_d  = 1'b1;
            end
        end

        dout_en_d = rd_act_d | inta_act_d;
        ready_d   = (state_d == ST_OPER);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_sync_q   <= '1;
            rd_sync_q   <= '1;
            inta_sync_q <= '1;
            wr_prev_q   <= 1'b1;
            rd_prev_q   <= 1'b1;
            inta_prev_q <= 1'b1;
            a0_lat_q    <= 1'b0;
            din_lat_q   <= 8'h00;
            cs_lat_q    <= 1'b1;
            ack_pend_q  <= 1'b0;
            wr_pend_q   <= 1'b0;
            rd_pend_q   <= 1'b0;
            wr_a0_p_q   <= 1'b0;
            wr_din_p_q  <= 8'h00;
            rd_a0_p_q   <= 1'b0;
            state_q     <= ST_UNINIT;
            ic4_q       <= 1'b0;
            ltim_q      <= 1'b0;
            aeoi_q      <= 1'b0;
            rsel_q      <= 1'b0;
            inta_cnt_q  <= 1'b0;
            base_q      <= 5'd0;
            imr_q       <= 8'h00;
`ifdef PIC_ICW3_EN
            sngl_q      <= 1'b0;
            cascade_q   <= 8'h00;
`endif
            prd_cap_q   <= 1'b0;
            vec_cap_q   <= 1'b0;
            rd_act_q    <= 1'b0;
            inta_act_q  <= 1'b0;
            cu_mode_q   <= CMD_IDLE;
            cu_data_q   <= 8'h00;
            cu_write_q  <= 1'b0;
            dout_q      <= 8'h00;
            dout_en_q   <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            wr_sync_q   <= wr_sync_d;
            rd_sync_q   <= rd_sync_d;
            inta_sync_q <= inta_sync_d;
            wr_prev_q   <= wr_prev_d;
            rd_prev_q   <= rd_prev_d;
            inta_prev_q <= inta_prev_d;
            a0_lat_q    <= a0_lat_d;
            din_lat_q   <= din_lat_d;
            cs_lat_q    <= cs_lat_d;
            ack_pend_q  <= ack_pend_d;
            wr_pend_q   <= wr_pend_d;
            rd_pend_q   <= rd_pend_d;
            wr_a0_p_q   <= wr_a0_p_d;
            wr_din_p_q  <= wr_din_p_d;
            rd_a0_p_q   <= rd_a0_p_d;
            state_q     <= state_d;
            ic4_q       <= ic4_d;
            ltim_q      <= ltim_d;
            aeoi_q      <= aeoi_d;
            rsel_q      <= rsel_d;
            inta_cnt_q  <= inta_cnt_d;
            base_q      <= base_d;
            imr_q       <= imr_d;
`ifdef PIC_ICW3_EN
            sngl_q      <= sngl_d;
            cascade_q   <= cascade_d;
`endif
            prd_cap_q   <= prd_cap_d;
            vec_cap_q   <= vec_cap_d;
            rd_act_q    <= rd_act_d;
            inta_act_q  <= inta_act_d;
            cu_mode_q   <= cu_mode_d;
            cu_data_q   <= cu_data_d;
            cu_write_q  <= cu_write_d;
            dout_q      <= dout_d;
            dout_en_q   <= dout_en_d;
            ready_q     <= ready_d;
        end
    end

    assign CU_MODE  = cu_mode_q;
    assign CU_DATA  = cu_data_q;
    assign CU_WRITE = cu_write_q;
    assign DOUT     = dout_q;
    assign DOUT_EN  = dout_en_q;
    assign READY    = ready_q;

endmodule

// File: tb/tb_pic_control_unit.sv
module tb_pic_control_unit;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs_n = 1'b1, wr_n = 1'b1, rd_n = 1'b1, a0 = 1'b0, inta_n = 1'b1;
    logic [7:0] din = 8'h00, pdata = 8'h00;
    logic [2:0] pmode = 3'b000;
    logic [2:0] cu_mode;
    logic [7:0] cu_data, dout;
    logic       cu_write, dout_en, ready;

    pic_control_unit #(.SYNC_STAGES(S)) dut (
        .CLK(clk), .RST_N(rst_n), .CS_N(cs_n), .WR_N(wr_n), .RD_N(rd_n),
        .A0(a0), .DIN(din), .INTA_N(inta_n),
        .PRIORITY_DATA(pdata), .PRIORITY_MODE(pmode),
        .CU_MODE(cu_mode), .CU_DATA(cu_data), .CU_WRITE(cu_write),
        .DOUT(dout), .DOUT_EN(dout_en), .READY(ready)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Command pulses seen during the last observation window.
    int         obs_cnt;
    int         obs_edge [0:3];
    logic [2:0] obs_mode [0:3];
    logic [7:0] obs_data [0:3];

    // Reference model: what the CPU has programmed so far.
    bit         m_inited, m_ready, m_ic4, m_sngl, m_ltim, m_aeoi, m_rsel, m_second;
    logic [4:0] m_base;
    logic [7:0] m_imr;
    int         m_todo[$];   // init words still owed after ICW1 (2,3,4)

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_inited = 0; m_ready = 0; m_ic4 = 0; m_sngl = 0; m_ltim = 0;
        m_aeoi = 0; m_rsel = 0; m_second = 0; m_base = 0; m_imr = 0;
        m_todo.delete();
    endfunction

    function automatic void model_write(input bit wa0, input logic [7:0] wd,
                                        output bit has, output logic [2:0] md,
                                        output logic [7:0] dt, output bit dc);
        int w;
        has = 0; md = 3'b101; dt = 8'h00; dc = 0;
        if (!wa0 && wd[4]) begin
            m_inited = 1; m_ready = 0;
            m_ic4 = wd[0]; m_sngl = wd[1]; m_ltim = wd[3];
            m_aeoi = 0; m_rsel = 0; m_second = 0;
            m_todo.delete();
            m_todo.push_back(2);
`ifdef PIC_ICW3_EN
            if (!m_sngl) m_todo.push_back(3);
`endif
            if (m_ic4) m_todo.push_back(4);
            has = 1; md = 3'b111; dc = 1;
        end else if (!m_inited) begin
            has = 0;
        end else if (!m_ready) begin
            if (wa0 && m_todo.size() > 0) begin
                w = m_todo.pop_front();
                if (w == 2) m_base = wd[7:3];
                if (w == 4) m_aeoi = wd[1];
                if (m_todo.size() == 0) begin
                    m_ready = 1; has = 1; md = 3'b100;
                    dt = {6'b0, m_ltim, m_aeoi};
                end
            end
        end else if (wa0) begin
            m_imr = wd; has = 1; md = 3'b010; dt = wd;
        end else if (!wd[3]) begin
            has = 1; md = 3'b011; dt = wd;
        end else if (wd[1]) begin
            m_rsel = wd[0];
        end
    endfunction

    task automatic observe(input int n);
        obs_cnt = 0;
        for (int e = 1; e <= n; e++) begin
            @(posedge clk); #1;
            if (cu_write && obs_cnt < 4) begin
                obs_edge[obs_cnt] = e;
                obs_mode[obs_cnt] = cu_mode;
                obs_data[obs_cnt] = cu_data;
                obs_cnt++;
            end
        end
    endtask

    task automatic check_cmd(input string tag, input bit has, input logic [2:0] md,
                             input logic [7:0] dt, input bit dc);
        chk({tag, " cmd_count"}, obs_cnt, has ? 1 : 0);
        if (has && obs_cnt > 0) begin
            chk({tag, " latency"}, obs_edge[0], S + 1);
            chk({tag, " mode"}, obs_mode[0], md);
            if (!dc) chk({tag, " data"}, obs_data[0], dt);
        end
    endtask

    task automatic do_write(input bit wa0, input logic [7:0] wd);
        bit has, dc; logic [2:0] md; logic [7:0] dt;
        @(negedge clk);
        cs_n = 0; a0 = wa0; din = wd; wr_n = 0;
        repeat (3) @(negedge clk);
        wr_n = 1;
        model_write(wa0, wd, has, md, dt, dc);
        observe(S + 3);
        $display("[TB] write a0=%0d din=%02h expect_cmd=%0d mode=%0d seen=%0d", wa0, wd, has, md, obs_cnt);
        check_cmd("write", has, md, dt, dc);
        chk("ready", ready, m_ready);
        @(negedge clk);
        cs_n = 1;
    endtask

    task automatic do_read(input bit ra0);
        bit has; logic [2:0] md; logic [7:0] exp_dout;
        pdata = 8'($urandom);
        has = 0; md = 3'b000;
        if (!m_inited)  exp_dout = 8'h00;
        else if (ra0)   exp_dout = m_imr;
        else begin has = 1; md = m_rsel ? 3'b001 : 3'b000; exp_dout = pdata; end
        @(negedge clk);
        cs_n = 0; a0 = ra0; rd_n = 0;
        observe(S + 3);
        $display("[TB] read a0=%0d expect_dout=%02h dout=%02h", ra0, exp_dout, dout);
        check_cmd("read", has, md, 8'h00, 1'b1);
        chk("read dout", dout, exp_dout);
        chk("read dout_en", dout_en, 1);
        @(negedge clk);
        rd_n = 1;
        repeat (S + 2) @(posedge clk);
        #1 chk("read dout_en_off", dout_en, 0);
        @(negedge clk);
        cs_n = 1;
    endtask

    // Returns whether this pulse is the vector pulse, updates the model.
    function automatic void model_inta(output bit has, output bit vec, output logic [7:0] v);
        has = 0; vec = 0; v = 8'h00;
        if (m_inited) begin
            has = 1;
            if (m_second) begin
                vec = 1;
                v = {m_base, (pmode == 3'b101) ? pdata[2:0] : 3'b111};
            end
            m_second = ~m_second;
        end
    endfunction

    task automatic do_inta(input logic [2:0] pm, input logic [7:0] pd);
        bit has, vec; logic [7:0] v;
        pmode = pm; pdata = pd;
        model_inta(has, vec, v);
        @(negedge clk);
        inta_n = 0;
        observe(S + 3);
        $display("[TB] inta pmode=%0d pdata=%02h vector_pulse=%0d expect=%02h dout=%02h", pm, pd, vec, v, dout);
        check_cmd("inta", has, 3'b110, 8'h00, 1'b1);
        if (vec) begin
            chk("inta vector", dout, v);
            chk("inta dout_en", dout_en, 1);
        end
        repeat (2) @(negedge clk);
        inta_n = 1;
        repeat (S + 2) @(posedge clk);
        #1 chk("inta dout_en_off", dout_en, 0);
    endtask

    function automatic logic [2:0] rand_bad_mode();
        logic [2:0] m;
        m = 3'($urandom_range(0, 6));
        if (m >= 3'd5) m = m + 3'd1;
        return m;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, " cu_mode"}, cu_mode, 3'b101);
        chk({tag, " cu_data"}, cu_data, 8'h00);
        chk({tag, " cu_write"}, cu_write, 0);
        chk({tag, " dout"}, dout, 8'h00);
        chk({tag, " dout_en"}, dout_en, 0);
        chk({tag, " ready"}, ready, 0);
    endtask

    initial begin
        bit has, vec, dc; logic [2:0] md; logic [7:0] dt, v;
        logic [7:0] r8;
        int op, nw;

        // Reset state.
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk) rst_n = 1;
        repeat (2) @(negedge clk);

        // UNINIT: writes, reads and INTA are ignored.
        do_write(1'b1, 8'h55);
        do_read(1'b1);
        do_read(1'b0);
        do_inta(3'b101, 8'h03);

        // Init sequence.
        do_write(1'b0, 8'h13);
        do_write(1'b1, 8'h40);
        do_write(1'b1, 8'h02);

        // OCW1 and IMR readback.
        do_write(1'b1, 8'hA5);
        do_read(1'b1);

        // INTA with valid level, then a spurious pair.
        do_inta(3'b101, 8'h03);
        do_inta(3'b101, 8'h03);
        do_inta(3'b101, 8'h03);
        do_inta(3'b010, 8'h05);

        // OCW3 selects ISR, A0=0 read issues 001.
        do_write(1'b0, 8'h0B);
        do_read(1'b0);

        // INTA fall and WR rise in the same cycle: ack first, write next.
        pmode = 3'b101; pdata = 8'h06;
        @(negedge clk);
        cs_n = 0; a0 = 1; din = 8'h3C; wr_n = 0;
        repeat (3) @(negedge clk);
        wr_n = 1; inta_n = 0;
        model_inta(has, vec, v);
        model_write(1'b1, 8'h3C, has, md, dt, dc);
        observe(S + 4);
        $display("[TB] inta+write same cycle seen=%0d", obs_cnt);
        chk("simul count", obs_cnt, 2);
        if (obs_cnt == 2) begin
            chk("simul ack edge", obs_edge[0], S + 1);
            chk("simul ack mode", obs_mode[0], 3'b110);
            chk("simul wr edge", obs_edge[1], S + 2);
            chk("simul wr mode", obs_mode[1], 3'b010);
            chk("simul wr data", obs_data[1], 8'h3C);
        end
        @(negedge clk);
        cs_n = 1;
        repeat (2) @(negedge clk);
        inta_n = 1;
        repeat (S + 2) @(posedge clk);
        do_inta(3'b101, 8'h01);   // closes the pair: vector 8'h41
        do_read(1'b1);

        // Randomised traffic against the model.
        for (int k = 0; k < 40; k++) begin
            op = $urandom_range(0, 6);
            r8 = 8'($urandom);
            case (op)
                0: do_write(1'b1, r8);
                1: do_write(1'b0, {r8[7:5], 2'b00, r8[2:0]});
                2: do_write(1'b0, {3'b000, 2'b01, 1'b0, r8[1:0]});
                3: do_read(r8[0]);
                4: do_inta(3'b101, r8);
                5: do_inta(rand_bad_mode(), r8);
                default: begin
                    do_write(1'b0, {3'b000, 1'b1, r8[3], 1'b0, r8[1:0]});
                    nw = m_todo.size();
                    for (int j = 0; j < nw; j++) do_write(1'b1, 8'($urandom));
                end
            endcase
        end

        // Reset in the middle of initialisation.
        do_write(1'b0, 8'h13);
        do_write(1'b1, 8'h40);
        @(negedge clk);
        rst_n = 0;
        #1 check_reset_outputs("midreset");
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
        do_write(1'b1, 8'h55);
        do_read(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
